// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the D-stage branch controller: branch opcodes, FSM states,
// BHT reset value and the 2-bit saturating counter step.
package branch_ctrl_pkg;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_BEQ  = 3'd1;
  localparam logic [2:0] OP_BNE  = 3'd2;
  localparam logic [2:0] OP_BGEZ = 3'd3;
  localparam logic [2:0] OP_BLTZ = 3'd4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t BHT_RESET = 2'b01;

  // Counter moves toward strongly taken (11) or strongly not-taken (00) and sticks there
  function automatic bht_cnt_t bht_step(input bht_cnt_t c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Bundle between the hazard unit / CMP operand path / NPC mux and the branch controller.
interface branch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      f_pc;
  logic             f_pred_taken;
  logic             d_valid;
  logic [2:0]       d_op;
  logic [31:0]      d_pc;
  logic             d_pred_taken;
  logic             d_opnd_ready;
  logic [31:0]      rs_val;
  logic [31:0]      rt_val;
  logic             stall_d;
  logic             redirect;
  logic             redirect_taken;
  logic             flush_f;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output f_pc, d_valid, d_op, d_pc, d_pred_taken, d_opnd_ready, rs_val, rt_val,
    input  f_pred_taken, stall_d, redirect, redirect_taken, flush_f, branch_cnt, mispred_cnt
  );

  modport slave (
    input  f_pc, d_valid, d_op, d_pc, d_pred_taken, d_opnd_ready, rs_val, rt_val,
    output f_pred_taken, stall_d, redirect, redirect_taken, flush_f, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_ctrl_cmp.sv
// CMP comparator: equality of A and B, and sign test of A (A >= 0 as signed).
module branch_ctrl_cmp (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        equ_o,
  output logic        gez_o
);
  assign equ_o = (a_i == b_i);
  assign gez_o = ~a_i[31];
endmodule

// File: rtl/branch_ctrl.sv
// D-stage branch controller: stalls until operands are forwarded, resolves through CMP,
// issues a one-cycle redirect/flush on mispredict and trains the 2-bit BHT used by F.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  branch_ctrl_if.slave bus
);
  localparam int BHT_N = 2 ** IDX_W;

  logic [1:0]       state_q, state_d;
  logic             redirect_q, flush_q, redirect_taken_q;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;
  bht_cnt_t         bht_q [BHT_N];

  logic             equ, gez;
  logic             is_br, taken, in_recover, resolve, mispred;
  logic [IDX_W-1:0] f_idx, d_idx;
  logic             unused_pc_bits;

  branch_ctrl_cmp u_cmp (
    .a_i   (bus.rs_val),
    .b_i   (bus.rt_val),
    .equ_o (equ),
    .gez_o (gez)
  );

  assign f_idx = bus.f_pc[IDX_W+1:2];
  assign d_idx = bus.d_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.f_pc[31:IDX_W+2], bus.f_pc[1:0],
                            bus.d_pc[31:IDX_W+2], bus.d_pc[1:0]};

  always_comb begin
    is_br      = bus.d_valid && (bus.d_op >= OP_BEQ) && (bus.d_op <= OP_BLTZ);
    in_recover = (state_q == S_RECOVER);
    case (bus.d_op)
      OP_BEQ:  taken = equ;
      OP_BNE:  taken = ~equ;
      OP_BGEZ: taken = gez;
      OP_BLTZ: taken = ~gez;
      OP_NONE: taken = 1'b0;
      default: taken = 1'b0;
    endcase
    resolve = is_br && bus.d_opnd_ready && !in_recover;
    mispred = taken ^ bus.d_pred_taken;
  end

  // IDLE and WAIT react identically to the current D instruction; RECOVER ignores it
  always_comb begin
    state_d = S_IDLE;
    if (!in_recover && is_br) begin
      if (!bus.d_opnd_ready) state_d = S_WAIT;
      else if (mispred)      state_d = S_RECOVER;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      redirect_q       <= 1'b0;
      flush_q          <= 1'b0;
      redirect_taken_q <= 1'b0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      redirect_q       <= resolve && mispred;
      flush_q          <= resolve && mispred;
      redirect_taken_q <= resolve && mispred && taken;
      if (resolve) begin
        if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
        if (mispred && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= BHT_RESET;
    end else if (resolve) begin
      bht_q[d_idx] <= bht_step(bht_q[d_idx], taken);
    end
  end

  // Stall is gated by reset so a held branch does not keep D frozen while reset is low
  assign bus.stall_d        = reset && is_br && !bus.d_opnd_ready && !in_recover;
  assign bus.f_pred_taken   = bht_q[f_idx][1];
  assign bus.redirect       = redirect_q;
  assign bus.flush_f        = flush_q;
  assign bus.redirect_taken = redirect_taken_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized traffic,
// all compared against a behavioural branch-predictor model kept in the bench.
module tb_branch_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_ctrl_if #(.CNT_W(16)) bus ();

  branch_ctrl #(.IDX_W(6), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nVectors = 0;
  int nMiscompares = 0;

  int          mBht [64];
  int unsigned mBranch, mMispred;
  bit          mRecover, mRedirect, mRtaken;

  logic [31:0] pool [4] = '{32'h0, 32'h5, 32'hFFFF_FFFF, 32'h8000_0000};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit valid, input logic [2:0] op, input logic [31:0] pc,
                               input bit pred, input bit ready, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [31:0] fpc);
    bus.d_valid      = valid;
    bus.d_op         = op;
    bus.d_pc         = pc;
    bus.d_pred_taken = pred;
    bus.d_opnd_ready = ready;
    bus.rs_val       = rs;
    bus.rt_val       = rt;
    bus.f_pc         = fpc;
  endtask

  function automatic bit modelTaken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    case (op)
      3'd1:    return rs == rt;
      3'd2:    return rs != rt;
      3'd3:    return $signed(rs) >= 0;
      3'd4:    return $signed(rs) < 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit modelIsBr();
    return bus.d_valid && (bus.d_op >= 3'd1) && (bus.d_op <= 3'd4);
  endfunction

  task automatic modelReset();
    foreach (mBht[i]) mBht[i] = 1;
    mBranch = 0; mMispred = 0;
    mRecover = 0; mRedirect = 0; mRtaken = 0;
  endtask

  // One clock: check combinational outputs before the edge, advance the model, check registers after
  task automatic stepCycle();
    bit br, tk;
    int fi, di;
    br = modelIsBr();
    tk = modelTaken(bus.d_op, bus.rs_val, bus.rt_val);
    fi = int'(bus.f_pc[7:2]);
    di = int'(bus.d_pc[7:2]);
    #1;
    checkOutput("stall_d", 32'(bus.stall_d), 32'(br && !bus.d_opnd_ready && !mRecover));
    checkOutput("f_pred_taken", 32'(bus.f_pred_taken), 32'(mBht[fi] >= 2));
    @(posedge clk);
    mRedirect = 0; mRtaken = 0;
    if (mRecover) begin
      mRecover = 0;
    end else if (br && bus.d_opnd_ready) begin
      if (mBranch < 65535) mBranch++;
      if (tk) mBht[di] = (mBht[di] == 3) ? 3 : mBht[di] + 1;
      else    mBht[di] = (mBht[di] == 0) ? 0 : mBht[di] - 1;
      if (tk != bus.d_pred_taken) begin
        if (mMispred < 65535) mMispred++;
        mRedirect = 1; mRtaken = tk; mRecover = 1;
      end
    end
    #1;
    checkOutput("redirect", 32'(bus.redirect), 32'(mRedirect));
    checkOutput("flush_f", 32'(bus.flush_f), 32'(mRedirect));
    checkOutput("redirect_taken", 32'(bus.redirect_taken), 32'(mRtaken));
    checkOutput("branch_cnt", 32'(bus.branch_cnt), mBranch);
    checkOutput("mispred_cnt", 32'(bus.mispred_cnt), mMispred);
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks outputs drop at once, optionally scans every BHT entry
  task automatic doReset(input string tag, input bit scanBht);
    reset = 1'b0;
    #1;
    checkOutput({tag, "_stall"}, 32'(bus.stall_d), 32'd0);
    checkOutput({tag, "_redirect"}, 32'(bus.redirect), 32'd0);
    checkOutput({tag, "_flush"}, 32'(bus.flush_f), 32'd0);
    checkOutput({tag, "_bcnt"}, 32'(bus.branch_cnt), 32'd0);
    checkOutput({tag, "_mcnt"}, 32'(bus.mispred_cnt), 32'd0);
    modelReset();
    if (scanBht) begin
      for (int i = 0; i < 64; i++) begin
        bus.f_pc = 32'(i) << 2;
        #1;
        checkOutput({tag, "_bht_scan"}, 32'(bus.f_pred_taken), 32'(mBht[i] >= 2));
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit hold;
    int stallSeen;
    applyStimulus(0, 3'd0, 32'h0, 0, 1, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    #2;

    $display("[TB] scenario 1: mispredicted taken BEQ");
    doReset("rst0", 1);
    applyStimulus(1, 3'd1, 32'h3000, 0, 1, 32'd5, 32'd5, 32'h0);
    stepCycle();
    checkOutput("t1_redirect", 32'(bus.redirect), 32'd1);
    checkOutput("t1_rtaken", 32'(bus.redirect_taken), 32'd1);
    checkOutput("t1_mispred", 32'(bus.mispred_cnt), 32'd1);
    applyStimulus(0, 3'd0, 32'h0, 0, 1, 32'h0, 32'h0, 32'h3000);
    #1;
    checkOutput("t1_fpred", 32'(bus.f_pred_taken), 32'd1);
    stepCycle();

    $display("[TB] scenario 2: BNE waits three cycles");
    doReset("rst1", 0);
    stallSeen = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 3'd2, 32'h3004, 1, 0, 32'd1, 32'd2, 32'h0);
      #1;
      if (bus.stall_d === 1'b1) stallSeen++;
      stepCycle();
    end
    applyStimulus(1, 3'd2, 32'h3004, 1, 1, 32'd1, 32'd2, 32'h0);
    #1;
    if (bus.stall_d === 1'b1) stallSeen++;
    stepCycle();
    checkOutput("t2_stall_cycles", 32'(stallSeen), 32'd3);
    checkOutput("t2_redirect", 32'(bus.redirect), 32'd0);
    checkOutput("t2_bcnt", 32'(bus.branch_cnt), 32'd1);
    checkOutput("t2_mcnt", 32'(bus.mispred_cnt), 32'd0);

    $display("[TB] scenario 3: BGEZ / BLTZ on a negative operand");
    applyStimulus(1, 3'd3, 32'h3008, 0, 1, 32'h8000_0000, 32'h0, 32'h0);
    stepCycle();
    checkOutput("t3_bgez_redirect", 32'(bus.redirect), 32'd0);
    applyStimulus(1, 3'd4, 32'h3008, 0, 1, 32'h8000_0000, 32'h0, 32'h3008);
    stepCycle();
    checkOutput("t3_bltz_redirect", 32'(bus.redirect), 32'd1);
    checkOutput("t3_bltz_rtaken", 32'(bus.redirect_taken), 32'd1);
    applyStimulus(0, 3'd0, 32'h0, 0, 1, 32'h0, 32'h0, 32'h3008);
    stepCycle();

    $display("[TB] scenario 4: branch in D during recovery");
    applyStimulus(1, 3'd1, 32'h300C, 0, 1, 32'd7, 32'd7, 32'h0);
    stepCycle();
    applyStimulus(1, 3'd1, 32'h300C, 0, 0, 32'd7, 32'd7, 32'h300C);
    #1;
    checkOutput("t4_stall", 32'(bus.stall_d), 32'd0);
    stepCycle();
    checkOutput("t4_redirect_drop", 32'(bus.redirect), 32'd0);
    checkOutput("t4_bcnt", 32'(bus.branch_cnt), 32'd4);
    applyStimulus(0, 3'd0, 32'h0, 0, 1, 32'h0, 32'h0, 32'h300C);
    stepCycle();

    $display("[TB] scenario 5: same-index read/update collision");
    applyStimulus(1, 3'd1, 32'h3010, 1, 1, 32'd3, 32'd3, 32'h3010);
    #1;
    checkOutput("t5_old_pred", 32'(bus.f_pred_taken), 32'd0);
    stepCycle();
    applyStimulus(0, 3'd0, 32'h0, 0, 1, 32'h0, 32'h0, 32'h3010);
    #1;
    checkOutput("t5_new_pred", 32'(bus.f_pred_taken), 32'd1);
    stepCycle();

    $display("[TB] scenario 6: reset during WAIT and RECOVER");
    applyStimulus(1, 3'd2, 32'h3014, 0, 0, 32'd1, 32'd1, 32'h0);
    stepCycle();
    doReset("rst_wait", 1);
    applyStimulus(1, 3'd1, 32'h3018, 0, 1, 32'd2, 32'd2, 32'h3018);
    stepCycle();
    doReset("rst_recover", 1);

    $display("[TB] randomized traffic");
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hold) begin
        applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                      32'h4000 + (32'($urandom_range(0, 7)) << 2), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2) != 0, pool[$urandom_range(0, 3)],
                      pool[$urandom_range(0, 3)], 32'h4000 + (32'($urandom_range(0, 7)) << 2));
      end else begin
        bus.d_opnd_ready = $urandom_range(0, 1) != 0;
      end
      hold = modelIsBr() && !bus.d_opnd_ready && !mRecover;
      stepCycle();
    end

    $display("[TB] scenario 7: counter saturation");
    doReset("rst_sat", 0);
    applyStimulus(1, 3'd1, 32'h3020, 1, 1, 32'd9, 32'd9, 32'h3020);
    repeat (70000) stepCycle();
    checkOutput("t7_bcnt_sat", 32'(bus.branch_cnt), 32'h0000_FFFF);
    checkOutput("t7_mcnt", 32'(bus.mispred_cnt), 32'd0);
    checkOutput("t7_pred", 32'(bus.f_pred_taken), 32'd1);
    applyStimulus(1, 3'd2, 32'h3020, 1, 1, 32'd9, 32'd9, 32'h3020);
    stepCycle();
    checkOutput("t7_bcnt_hold", 32'(bus.branch_cnt), 32'h0000_FFFF);
    applyStimulus(0, 3'd0, 32'h0, 0, 1, 32'h0, 32'h0, 32'h3020);
    stepCycle();
    stepCycle();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
